// File: rtl/rah_pkg.sv
// ---------------------------------------------------------------------------
// rah_pkg
// Shared definitions for the RAH frame decoder:
//   - header word field positions (LEN, app_id, magic)
//   - default header marker value
//   - decoder state encoding (IDLE, HDR, DATA, SKIP)
// ---------------------------------------------------------------------------
package rah_pkg;

  // Header word layout; bits above MAGIC_MSB carry no meaning.
  localparam int LEN_LSB   = 0;
  localparam int LEN_MSB   = 15;
  localparam int APPID_LSB = 16;
  localparam int APPID_MSB = 23;
  localparam int MAGIC_LSB = 24;
  localparam int MAGIC_MSB = 31;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

  // Decoder state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_SKIP = 2'd3;

endpackage

// File: rtl/rah_decoder_if.sv
// ---------------------------------------------------------------------------
// rah_decoder_if
// Stream and app-write bus of the RAH decoder.
//   rx_frame_start  frame start pulse from the capture logic
//   rx_valid        rx_data valid this cycle
//   rx_data         incoming stream word
//   app_fifo_full   per-app downstream FIFO full
//   app_wr_en       one-hot per-app write strobe
//   app_wr_data     payload word shared by all apps
//   app_sop/app_eop first/last payload word markers
// modport master: the environment side (drives the stream, sinks writes)
// modport slave : the decoder side
// ---------------------------------------------------------------------------
interface rah_decoder_if #(
  parameter int TOTAL_APPS = 4,
  parameter int DATA_WIDTH = 128
);

  logic                  rx_frame_start;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic [TOTAL_APPS-1:0] app_fifo_full;
  logic [TOTAL_APPS-1:0] app_wr_en;
  logic [DATA_WIDTH-1:0] app_wr_data;
  logic                  app_sop;
  logic                  app_eop;

  modport master (
    output rx_frame_start, rx_valid, rx_data, app_fifo_full,
    input  app_wr_en, app_wr_data, app_sop, app_eop
  );

  modport slave (
    input  rx_frame_start, rx_valid, rx_data, app_fifo_full,
    output app_wr_en, app_wr_data, app_sop, app_eop
  );

endinterface

// File: rtl/rah_hdr_parse.sv
// ---------------------------------------------------------------------------
// rah_hdr_parse
// Purely combinational split of a header word into its fields.
//   word          low 32 bits of the stream word
//   magic_ok      marker field equals MAGIC
//   app_id        target app field
//   len           payload word count
//   app_in_range  app_id addresses an existing app channel
// ---------------------------------------------------------------------------
module rah_hdr_parse
  import rah_pkg::*;
#(
  parameter int         TOTAL_APPS = 4,
  parameter logic [7:0] MAGIC      = DEFAULT_MAGIC
) (
  input  logic [31:0] word,
  output logic        magic_ok,
  output logic [7:0]  app_id,
  output logic [15:0] len,
  output logic        app_in_range
);

  // Nine bits so that TOTAL_APPS = 256 is representable.
  localparam logic [8:0] APP_LIMIT = 9'(TOTAL_APPS);

  assign magic_ok     = (word[MAGIC_MSB:MAGIC_LSB] == MAGIC);
  assign app_id       = word[APPID_MSB:APPID_LSB];
  assign len          = word[LEN_MSB:LEN_LSB];
  assign app_in_range = ({1'b0, app_id} < APP_LIMIT);

endmodule

// File: rtl/rah_decoder.sv
// ---------------------------------------------------------------------------
// rah_decoder
// Receive-side RAH frame parser. Each packet is one header word followed by
// LEN payload words, which are steered to the app chosen by the header. The
// stream cannot be stalled: words for a full FIFO are dropped and flagged in
// a sticky per-app overflow bit.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        rah_decoder_if.slave (stream in, app writes out)
//   ovf_clr    per-app clear of app_ovf
//   err_hdr    pulse: bad magic or app_id out of range
//   err_abort  pulse: frame start while a packet was incomplete
//   app_ovf    sticky per-app drop flag
//   busy       high while in DATA or SKIP
//   frame_cnt, pkt_cnt  (only with RAH_DECODER_STATS_EN) frame and accepted
//                       header counters, wrapping at 2^16
//
// Optional feature macro: RAH_DECODER_STATS_EN
// ---------------------------------------------------------------------------
module rah_decoder
  import rah_pkg::*;
#(
  parameter int         TOTAL_APPS = 4,
  parameter int         DATA_WIDTH = 128,
  parameter logic [7:0] MAGIC      = DEFAULT_MAGIC
) (
  input  logic                  clk,
  input  logic                  rst,
  rah_decoder_if.slave          bus,
  input  logic [TOTAL_APPS-1:0] ovf_clr,
  output logic                  err_hdr,
  output logic                  err_abort,
  output logic [TOTAL_APPS-1:0] app_ovf,
  output logic                  busy
`ifdef RAH_DECODER_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           pkt_cnt
`endif
);

  logic [1:0]            state;
  logic [15:0]           cnt;
  logic [15:0]           len_q;
  logic [TOTAL_APPS-1:0] sel_q;

  logic [TOTAL_APPS-1:0] wr_en_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  sop_q;
  logic                  eop_q;

  logic                  p_magic_ok;
  logic [7:0]            p_app_id;
  logic [15:0]           p_len;
  logic                  p_in_range;

  logic                  hdr_mode;
  logic                  in_pkt;
  logic                  word_last;
  logic                  sel_full;
  logic                  hdr_accept;
  logic [TOTAL_APPS-1:0] hdr_sel;
  logic [TOTAL_APPS-1:0] ovf_set;

  rah_hdr_parse #(
    .TOTAL_APPS (TOTAL_APPS),
    .MAGIC      (MAGIC)
  ) u_hdr_parse (
    .word         (bus.rx_data[31:0]),
    .magic_ok     (p_magic_ok),
    .app_id       (p_app_id),
    .len          (p_len),
    .app_in_range (p_in_range)
  );

  // A frame start forces header parsing this very cycle, whatever the state,
  // so a word arriving together with it is always read as a header.
  always_comb begin
    hdr_mode   = bus.rx_frame_start || (state == ST_HDR);
    in_pkt     = ((state == ST_DATA) || (state == ST_SKIP)) && !bus.rx_frame_start;
    word_last  = (cnt == (len_q - 16'd1));
    sel_full   = |(bus.app_fifo_full & sel_q);
    hdr_accept = hdr_mode && bus.rx_valid && p_magic_ok && (p_len != 16'd0);
    hdr_sel    = TOTAL_APPS'(1) << p_app_id;
    ovf_set    = '0;
    if (in_pkt && (state == ST_DATA) && bus.rx_valid && sel_full) begin
      ovf_set = sel_q;
    end
  end

  // Packet FSM, payload counter and registered app-side outputs.
  // The target app is held as a one-hot mask so it can drive app_wr_en and
  // pick the matching FIFO-full bit without any index arithmetic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 16'd0;
      len_q     <= 16'd0;
      sel_q     <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      err_hdr   <= 1'b0;
      err_abort <= 1'b0;
      app_ovf   <= '0;
    end else begin
      wr_en_q   <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      err_hdr   <= 1'b0;
      err_abort <= 1'b0;
      app_ovf   <= (app_ovf & ~ovf_clr) | ovf_set;

      if (bus.rx_frame_start && ((state == ST_DATA) || (state == ST_SKIP))) begin
        err_abort <= 1'b1;
      end

      if (hdr_mode) begin
        state <= ST_HDR;
        cnt   <= 16'd0;
        if (bus.rx_valid) begin
          if (!p_magic_ok) begin
            err_hdr <= 1'b1;
          end else if (p_len != 16'd0) begin
            len_q <= p_len;
            if (p_in_range) begin
              sel_q <= hdr_sel;
              state <= ST_DATA;
            end else begin
              err_hdr <= 1'b1;
              state   <= ST_SKIP;
            end
          end
        end
      end else if (in_pkt && bus.rx_valid) begin
        // Markers ride only on real writes; a dropped word leaves no strobe.
        if ((state == ST_DATA) && !sel_full) begin
          wr_en_q   <= sel_q;
          wr_data_q <= bus.rx_data;
          sop_q     <= (cnt == 16'd0);
          eop_q     <= word_last;
        end
        if (word_last) begin
          state <= ST_HDR;
          cnt   <= 16'd0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

`ifdef RAH_DECODER_STATS_EN
  // Free-running statistics, wrapping modulo 2^16.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'd0;
      pkt_cnt   <= 16'd0;
    end else begin
      if (bus.rx_frame_start) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (hdr_accept) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats = hdr_accept;
`endif

  assign busy            = (state == ST_DATA) || (state == ST_SKIP);
  assign bus.app_wr_en   = wr_en_q;
  assign bus.app_wr_data = wr_data_q;
  assign bus.app_sop     = sop_q;
  assign bus.app_eop     = eop_q;

endmodule

// File: tb/tb_rah_decoder.sv
// ---------------------------------------------------------------------------
// tb_rah_decoder
// Directed, table-driven bench for rah_decoder (TOTAL_APPS = 4,
// DATA_WIDTH = 128). Each table row is one clock cycle: the inputs applied
// before the edge and the outputs expected just after it.
// ---------------------------------------------------------------------------
module tb_rah_decoder;

  localparam int NA = 4;
  localparam int DW = 128;

  typedef struct {
    logic          fs;
    logic          valid;
    logic [DW-1:0] data;
    logic [NA-1:0] full;
    logic [NA-1:0] clr;
    logic [NA-1:0] exp_wr;
    logic [DW-1:0] exp_data;
    logic          exp_sop;
    logic          exp_eop;
    logic          exp_eh;
    logic          exp_ea;
    logic [NA-1:0] exp_ovf;
    logic          exp_busy;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [NA-1:0] ovf_clr;
  logic          err_hdr;
  logic          err_abort;
  logic [NA-1:0] app_ovf;
  logic          busy;
`ifdef RAH_DECODER_STATS_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   pkt_cnt;
`endif

  int testsRun;
  int testsFailed;
  vec_t vecs[$];

  rah_decoder_if #(.TOTAL_APPS(NA), .DATA_WIDTH(DW)) bus ();

  rah_decoder #(.TOTAL_APPS(NA), .DATA_WIDTH(DW), .MAGIC(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ovf_clr   (ovf_clr),
    .err_hdr   (err_hdr),
    .err_abort (err_abort),
    .app_ovf   (app_ovf),
    .busy      (busy)
`ifdef RAH_DECODER_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .pkt_cnt   (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] hdr(input logic [7:0] magic, input logic [7:0] app,
                                        input logic [15:0] len);
    return {96'hFEED0000CAFE000012345678, magic, app, len};
  endfunction

  function automatic logic [DW-1:0] pw(input logic [7:0] t);
    return {16{t}};
  endfunction

  task automatic addVec(input logic fs, input logic valid, input logic [DW-1:0] data,
                        input logic [NA-1:0] full, input logic [NA-1:0] clr,
                        input logic [NA-1:0] exp_wr, input logic [DW-1:0] exp_data,
                        input logic exp_sop, input logic exp_eop, input logic exp_eh,
                        input logic exp_ea, input logic [NA-1:0] exp_ovf,
                        input logic exp_busy);
    vec_t v;
    v.fs = fs; v.valid = valid; v.data = data; v.full = full; v.clr = clr;
    v.exp_wr = exp_wr; v.exp_data = exp_data; v.exp_sop = exp_sop;
    v.exp_eop = exp_eop; v.exp_eh = exp_eh; v.exp_ea = exp_ea;
    v.exp_ovf = exp_ovf; v.exp_busy = exp_busy;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string tag, input string name,
                          input logic [DW-1:0] act, input logic [DW-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s %s: got %0h, expected %0h", tag, name, act, exp);
    end
  endtask

  // Drive one cycle of inputs away from the edge, then settle past the edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.rx_frame_start = v.fs;
    bus.rx_valid       = v.valid;
    bus.rx_data        = v.data;
    bus.app_fifo_full  = v.full;
    ovf_clr            = v.clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkVal(tag, "wr_en", DW'(bus.app_wr_en), DW'(v.exp_wr));
    if (v.exp_wr != '0) checkVal(tag, "wr_data", bus.app_wr_data, v.exp_data);
    checkVal(tag, "sop", DW'(bus.app_sop), DW'(v.exp_sop));
    checkVal(tag, "eop", DW'(bus.app_eop), DW'(v.exp_eop));
    checkVal(tag, "err_hdr", DW'(err_hdr), DW'(v.exp_eh));
    checkVal(tag, "err_abort", DW'(err_abort), DW'(v.exp_ea));
    checkVal(tag, "app_ovf", DW'(app_ovf), DW'(v.exp_ovf));
    checkVal(tag, "busy", DW'(busy), DW'(v.exp_busy));
  endtask

  initial begin
    vec_t v;
    testsRun    = 0;
    testsFailed = 0;
    rst = 1'b1;
    bus.rx_frame_start = 1'b0;
    bus.rx_valid       = 1'b0;
    bus.rx_data        = '0;
    bus.app_fifo_full  = '0;
    ovf_clr            = '0;

    //      fs valid data               full     clr      wr       data      sop eop eh ea ovf     busy
    addVec(0, 1, hdr(8'hA5,8'd2,16'd3), 4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 0); // idle ignores
    addVec(1, 1, hdr(8'hA5,8'd2,16'd3), 4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 1);
    addVec(0, 1, pw(8'hD0),             4'h0, 4'h0, 4'b0100, pw(8'hD0), 1, 0, 0, 0, 4'h0, 1);
    addVec(0, 1, pw(8'hD1),             4'h0, 4'h0, 4'b0100, pw(8'hD1), 0, 0, 0, 0, 4'h0, 1);
    addVec(0, 1, pw(8'hD2),             4'h0, 4'h0, 4'b0100, pw(8'hD2), 0, 1, 0, 0, 4'h0, 0);
    addVec(0, 0, '0,                    4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 0);
    addVec(0, 1, hdr(8'h5A,8'd0,16'd1), 4'h0, 4'h0, 4'b0000, '0,        0, 0, 1, 0, 4'h0, 0); // bad magic
    addVec(0, 1, hdr(8'hA5,8'd0,16'd1), 4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 1);
    addVec(0, 1, pw(8'hE0),             4'h0, 4'h0, 4'b0001, pw(8'hE0), 1, 1, 0, 0, 4'h0, 0);
    addVec(0, 1, hdr(8'hA5,8'd7,16'd2), 4'h0, 4'h0, 4'b0000, '0,        0, 0, 1, 0, 4'h0, 1); // skip
    addVec(0, 1, pw(8'hF0),             4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 1);
    addVec(0, 0, '0,                    4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 1);
    addVec(0, 1, pw(8'hF1),             4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 0);
    addVec(0, 1, hdr(8'hA5,8'd1,16'd1), 4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 1);
    addVec(0, 1, pw(8'hC0),             4'h0, 4'h0, 4'b0010, pw(8'hC0), 1, 1, 0, 0, 4'h0, 0);
    addVec(0, 1, hdr(8'hA5,8'd3,16'd4), 4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 1); // overflow
    addVec(0, 1, pw(8'hB0),             4'h0, 4'h0, 4'b1000, pw(8'hB0), 1, 0, 0, 0, 4'h0, 1);
    addVec(0, 1, pw(8'hB1),             4'h8, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h8, 1);
    addVec(0, 1, pw(8'hB2),             4'h0, 4'h0, 4'b1000, pw(8'hB2), 0, 0, 0, 0, 4'h8, 1);
    addVec(0, 1, pw(8'hB3),             4'h0, 4'h0, 4'b1000, pw(8'hB3), 0, 1, 0, 0, 4'h8, 0);
    addVec(0, 0, '0,                    4'h0, 4'h7, 4'b0000, '0,        0, 0, 0, 0, 4'h8, 0);
    addVec(0, 0, '0,                    4'h0, 4'h8, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 0);
    addVec(0, 1, hdr(8'hA5,8'd3,16'd1), 4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 1); // set beats clr
    addVec(0, 1, pw(8'hA0),             4'h8, 4'h8, 4'b0000, '0,        0, 0, 0, 0, 4'h8, 0);
    addVec(0, 0, '0,                    4'h0, 4'h8, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 0);
    addVec(0, 1, hdr(8'hA5,8'd1,16'd5), 4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 1); // abort
    addVec(0, 1, pw(8'h90),             4'h0, 4'h0, 4'b0010, pw(8'h90), 1, 0, 0, 0, 4'h0, 1);
    addVec(0, 1, pw(8'h91),             4'h0, 4'h0, 4'b0010, pw(8'h91), 0, 0, 0, 0, 4'h0, 1);
    addVec(1, 1, hdr(8'hA5,8'd1,16'd1), 4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 1, 4'h0, 1);
    addVec(0, 1, pw(8'h80),             4'h0, 4'h0, 4'b0010, pw(8'h80), 1, 1, 0, 0, 4'h0, 0);
    addVec(1, 0, '0,                    4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 0); // fs in HDR
    addVec(0, 1, hdr(8'hA5,8'd2,16'd0), 4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 0); // LEN 0
    addVec(0, 1, hdr(8'hA5,8'd5,16'd3), 4'h0, 4'h0, 4'b0000, '0,        0, 0, 1, 0, 4'h0, 1);
    addVec(0, 1, pw(8'h70),             4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 1);
    addVec(1, 0, '0,                    4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 1, 4'h0, 0); // abort SKIP
    addVec(0, 1, hdr(8'hA5,8'd0,16'd1), 4'h0, 4'h0, 4'b0000, '0,        0, 0, 0, 0, 4'h0, 1);
    addVec(0, 1, pw(8'h60),             4'hE, 4'h0, 4'b0001, pw(8'h60), 1, 1, 0, 0, 4'h0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    v = vecs[0];
    v.exp_busy = 1'b0;
    checkOutput("reset", v);
    checkVal("reset", "wr_data", bus.app_wr_data, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Hand sequence: reset in the middle of a packet with a sticky flag set.
    v = vecs[0];
    v.fs = 0; v.valid = 1; v.data = hdr(8'hA5, 8'd0, 16'd3); v.exp_busy = 1;
    applyStimulus(v);
    checkOutput("rst_hdr", v);
    v.data = pw(8'h50); v.full = 4'h1; v.exp_ovf = 4'h1;
    applyStimulus(v);
    checkOutput("rst_drop", v);
    @(negedge clk);
    rst = 1'b1;
    v.data = pw(8'h51); v.full = 4'h0; v.exp_ovf = 4'h0; v.exp_busy = 0;
    applyStimulus(v);
    checkOutput("rst_mid", v);
    checkVal("rst_mid", "wr_data", bus.app_wr_data, '0);
    @(negedge clk);
    rst = 1'b0;
    v.data = pw(8'h52);
    applyStimulus(v);
    checkOutput("rst_idle_word", v);
    v.data = hdr(8'hA5, 8'd0, 16'd1);
    applyStimulus(v);
    checkOutput("rst_idle_hdr", v);
    v.fs = 1; v.exp_busy = 1;
    applyStimulus(v);
    checkOutput("rst_new_frame", v);
    v.fs = 0; v.data = pw(8'h40); v.exp_wr = 4'b0001; v.exp_data = pw(8'h40);
    v.exp_sop = 1; v.exp_eop = 1; v.exp_busy = 0;
    applyStimulus(v);
    checkOutput("rst_resume", v);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rah_decoder.md
Name: rah_decoder

Overview:
- Receive-side counterpart of the RAH frame encoder: parses the frame stream arriving from the processor and demultiplexes packets to per-app write ports.
- Downstream of the MIPI/video receive capture logic; upstream of the per-app RX FIFOs.
- Each packet is one header word followed by LEN payload words. The payload is steered to the app selected by the header.
- The input stream cannot be stalled. Words that cannot be accepted are dropped and flagged.

Parameters:
- TOTAL_APPS, 4, number of app channels (1..256).
- DATA_WIDTH, 128, stream/payload word width (>= 32).
- MAGIC, 8'hA5, header marker value.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_frame_start  input  1  one-cycle pulse marking the start of a frame (vsync-derived); may coincide with the first rx_valid word.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_data  input  DATA_WIDTH  stream word.
- app_fifo_full  input  TOTAL_APPS  per-app downstream FIFO full.
- ovf_clr  input  TOTAL_APPS  per-app clear of the sticky overflow bits.
- app_wr_en  output  TOTAL_APPS  one-hot write strobe.
- app_wr_data  output  DATA_WIDTH  payload word, shared by all apps.
- app_sop  output  1  asserted with the first payload word of a packet.
- app_eop  output  1  asserted with the last payload word of a packet.
- err_hdr  output  1  one-cycle pulse: bad magic or app_id out of range.
- err_abort  output  1  one-cycle pulse: frame_start arrived while a packet was incomplete.
- app_ovf  output  TOTAL_APPS  sticky: a payload word was dropped because the FIFO was full.
- busy  output  1  high while in DATA or SKIP.

Behaviour:
- Header word fields:
  - [15:0] LEN, payload word count.
  - [23:16] app_id.
  - [31:24] magic.
  - Upper bits are ignored.
- Reset:
  - All outputs go to 0; app_wr_data goes to 0.
  - State goes to IDLE; word counter goes to 0.
- State IDLE:
  - Ignores rx_valid until rx_frame_start.
  - On rx_frame_start, moves to HDR. If rx_valid is high in the same cycle, that word is parsed as a header.
- State HDR, on each rx_valid word:
  - Magic != MAGIC: pulse err_hdr, stay in HDR.
  - Magic OK, LEN == 0: no write, stay in HDR.
  - Magic OK, app_id >= TOTAL_APPS: pulse err_hdr, latch LEN, go to SKIP.
  - Otherwise: latch app_id and LEN, go to DATA.
- State DATA, on each rx_valid word:
  - Word counter increments.
  - If app_fifo_full[app_id] is 0, assert app_wr_en[app_id] next cycle with app_wr_data equal to the word.
  - If app_fifo_full[app_id] is 1, drop the word and set app_ovf[app_id].
  - app_sop is asserted on counter 0; app_eop on counter LEN-1.
  - app_sop and app_eop are asserted only together with an actual write. A dropped word produces no strobe.
  - After LEN words, return to HDR.
- State SKIP: consumes LEN words with no writes, then returns to HDR.
- Latency: exactly 1 cycle from an rx_data word to app_wr_en/app_wr_data (registered outputs).
- app_wr_en is at most one-hot and never asserted while rx_valid is low.
- rx_frame_start in HDR: stay in HDR, no error.
- rx_frame_start in DATA or SKIP:
  - Pulse err_abort and go to HDR.
  - A word valid in the same cycle is parsed as a header.
  - The partial packet receives no eop.
- app_ovf:
  - Set has priority over ovf_clr in the same cycle.
  - Bits are independent per app.
- LEN counter is 16 bits. LEN = 65535 is legal; there is no wrap beyond LEN-1.
- rst mid-packet: immediate return to IDLE. The next frame is needed before parsing resumes.

Optional Feature:
- Macro: RAH_DECODER_STATS_EN.
- With the macro, two extra outputs:
  - frame_cnt [15:0]: increments on each rx_frame_start.
  - pkt_cnt [15:0]: increments on each accepted header, including SKIP headers.
  - Both wrap modulo 2^16 and reset to 0.
- Without the macro, the ports and counters are absent and no logic is added.

Decomposition:
- Package rah_pkg:
  - Header field offsets and widths (LEN_LSB/MSB, APPID_LSB/MSB, MAGIC_LSB/MSB).
  - Default MAGIC.
  - Decoder state enum (IDLE, HDR, DATA, SKIP).
- Sub-module rah_hdr_parse, purely combinational:
  - Input: a word.
  - Outputs: magic_ok, app_id, len, app_in_range.
  - Instantiated once in rah_decoder.
  - The FSM, counter and output registers stay in the top module.

Test Plan:
- Frame with header {A5, app 2, LEN 3} and payload D0..D2, all FIFOs empty -> app_wr_en = 4'b0100 for 3 cycles, each 1 cycle after its input word; data D0..D2; sop on D0; eop on D2.
- Header with magic 0x5A, then a valid header {A5, app 0, LEN 1} -> err_hdr pulses once; app 0 receives 1 word.
- Header {A5, app 7, LEN 2} with TOTAL_APPS = 4, then 2 words, then {A5, app 1, LEN 1} -> err_hdr; no writes for the 2 skipped words; app 1 receives 1 word.
- app_fifo_full[3] = 1 during the 2nd of 4 payload words to app 3 -> 3 writes, no strobe for the dropped word, app_ovf[3] = 1 until ovf_clr[3] is pulsed.
- rx_frame_start after 2 of 5 payload words, with a valid header {A5, app 1, LEN 1} in the same cycle -> err_abort pulse; no eop for the partial packet; app 1 receives 1 word.
- rst asserted mid-DATA -> all outputs 0 next cycle; words ignored until the next rx_frame_start.
